instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 162 ++++++++++++++++
 tb/tb_instr_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Instruction loader: encodes RV32I-style requests into instruction words and writes
// them to consecutive memory slots, closing the program with an all-ones terminator.
module instr_loader #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [2:0]  req_funct3,
  input  logic        req_alt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  input  logic        finish,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [7:0]  count,
  output logic        full,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, ENCODE, WRITE, TERM, DONE} state_e;

  localparam logic [7:0] LAST = 8'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [2:0]         kind_q, f3_q;
  logic               alt_q;
  logic [4:0]         rd_q, rs1_q, rs2_q;
  logic [31:0]        imm_q;
  logic signed [31:0] imm_s;
  logic [7:0]         count_q, count_d;
  logic               err_q, err_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        word;
  logic               legal;
  logic               hs;

  assign full      = (count_q == LAST);
  assign req_ready = (state_q == IDLE) && !full;
  assign hs        = req_valid && req_ready;
  assign imm_s     = imm_q;

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;
  assign done       = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      kind_q <= req_kind;
      f3_q   <= req_funct3;
      alt_q  <= req_alt;
      rd_q   <= req_rd;
      rs1_q  <= req_rs1;
      rs2_q  <= req_rs2;
      imm_q  <= req_imm;
    end
  end

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (kind_q)
      3'd0: word = {(alt_q ? 7'b0100000 : 7'b0000000), rs2_q, rs1_q, f3_q, rd_q, 7'b0110011};
      3'd1: begin
        word  = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0010011};
        legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      end
      3'd2: begin
        word  = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0000011};
        legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      end
      3'd3: begin
        word  = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], 7'b0100011};
        legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      end
      3'd4: begin
        word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], 7'b1100011};
        legal = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm_q[0];
      end
      3'd5: begin
        word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'b1101111};
        legal = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm_q[0];
      end
      3'd6: begin
        word  = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b1100111};
        legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // A handshake wins over finish when both arrive together.
        if (hs)          state_d = ENCODE;
        else if (finish) state_d = TERM;
      end
      ENCODE:  state_d = legal ? WRITE : IDLE;
      WRITE:   state_d = IDLE;
      TERM:    state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Write-port outputs are registered, so the pulse appears one cycle after WRITE/TERM.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ENCODE: if (!legal) err_d = 1'b1;
      WRITE: begin
        we_d    = 1'b1;
        addr_d  = {22'd0, count_q, 2'b00};
        wdata_d = word;
        count_d = count_q + 8'd1;
      end
      TERM: begin
        we_d    = 1'b1;
        addr_d  = {22'd0, count_q, 2'b00};
        wdata_d = '1;
        count_d = count_q + 8'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader (DEPTH=4): directed spec vectors plus randomized requests
// compared against an arithmetic encoding/legality model and a write log.
module tb_instr_loader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_kind, req_funct3;
  logic        req_alt;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        finish;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic [7:0]  count;
  logic        full, done, err;

  instr_loader #(.DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_funct3(req_funct3), .req_alt(req_alt),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .finish(finish), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t wq[$];

  always @(negedge clk) if (imem_we) wq.push_back('{cyc, imem_addr, imem_wdata});

  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt;
  bit m_err, m_done;
  logic [31:0] last_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int kind, input int f3, input int alt,
                                             input int rd, input int rs1, input int rs2,
                                             input int imm);
    int unsigned u;
    u = imm;
    case (kind)
      0: return ((alt != 0) ? (32'h20 << 25) : 32'h0) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h33;
      1: return ((u & 32'hFFF) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h13;
      2: return ((u & 32'hFFF) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h03;
      3: return (((u >> 5) & 32'h7F) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
                + ((u & 32'h1F) << 7) + 32'h23;
      4: return (((u >> 12) & 1) << 31) + (((u >> 5) & 32'h3F) << 25) + (rs2 << 20) + (rs1 << 15)
                + (f3 << 12) + (((u >> 1) & 32'hF) << 8) + (((u >> 11) & 1) << 7) + 32'h63;
      5: return (((u >> 20) & 1) << 31) + (((u >> 1) & 32'h3FF) << 21) + (((u >> 11) & 1) << 20)
                + (((u >> 12) & 32'hFF) << 12) + (rd << 7) + 32'h6F;
      6: return ((u & 32'hFFF) << 20) + (rs1 << 15) + (rd << 7) + 32'h67;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_legal(input int kind, input int imm);
    case (kind)
      0: return 1'b1;
      1, 2, 3, 6: return (imm >= -2048) && (imm <= 2047);
      4: return (imm >= -4096) && (imm <= 4094) && ((imm % 2) == 0);
      5: return (imm >= -1048576) && (imm <= 1048574) && ((imm % 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; finish = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wq.delete();
    m_cnt = 0; m_err = 1'b0; m_done = 1'b0;
  endtask

  // Presents a request and returns the cycle number of its handshake edge (-1 on timeout).
  task automatic do_req(input int kind, input int f3, input int alt, input int rd,
                        input int rs1, input int rs2, input int imm, input bit fin,
                        output int hs);
    int n;
    @(negedge clk);
    req_kind = 3'(kind); req_funct3 = 3'(f3); req_alt = 1'(alt);
    req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2); req_imm = imm;
    req_valid = 1'b1; finish = fin;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("hs_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      hs = -1;
      return;
    end
    hs = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_req(input int kind, input int f3, input int alt, input int rd,
                         input int rs1, input int rs2, input int imm);
    int hs;
    wr_t w;
    do_req(kind, f3, alt, rd, rs1, rs2, imm, 1'b0, hs);
    repeat (3) @(negedge clk);
    if (hs < 0) return;
    if (model_legal(kind, imm)) begin
      check("wr_seen", wq.size(), 1);
      if (wq.size() > 0) begin
        w = wq.pop_front();
        check("wr_addr", w.addr, 4 * m_cnt);
        check("wr_data", w.data, model_word(kind, f3, alt, rd, rs1, rs2, imm));
        check("wr_lat", w.cyc, hs + 2);
        last_data = w.data;
      end
      m_cnt++;
    end else begin
      m_err = 1'b1;
      check("no_wr", wq.size(), 0);
      wq.delete();
    end
    check("count", count, m_cnt);
    check("err", err, m_err);
    check("full", full, (m_cnt == DEPTH - 1));
    check("ready", req_ready, (m_cnt != DEPTH - 1));
  endtask

  task automatic run_finish();
    int hs;
    wr_t w;
    @(negedge clk);
    finish = 1'b1;
    hs = cyc + 1;
    @(negedge clk);
    finish = 1'b0;
    repeat (2) @(negedge clk);
    check("term_seen", wq.size(), 1);
    if (wq.size() > 0) begin
      w = wq.pop_front();
      check("term_addr", w.addr, 4 * m_cnt);
      check("term_data", w.data, 32'hFFFF_FFFF);
      check("term_lat", w.cyc, hs + 1);
    end
    m_cnt++;
    m_done = 1'b1;
    check("term_count", count, m_cnt);
    check("term_done", done, 1);
    check("term_ready", req_ready, 0);
  endtask

  task automatic poke_done();
    @(negedge clk);
    req_valid = 1'b1; finish = 1'b1; req_kind = 3'd0;
    repeat (4) @(negedge clk);
    req_valid = 1'b0; finish = 1'b0;
    repeat (2) @(negedge clk);
    check("done_no_wr", wq.size(), 0);
    check("done_hold", done, 1);
    check("done_count", count, m_cnt);
    check("done_ready", req_ready, 0);
    wq.delete();
  endtask

  function automatic int rand_imm();
    int bnd[15] = '{-2048, 2047, -2049, 2048, -4096, 4094, 4095, -4098, 4096,
                    1048574, -1048576, 1048576, -1048578, 3, -1};
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 8191)) - 4096;
      1: return bnd[$urandom_range(0, 14)];
      2: return int'($urandom());
      default: return int'($urandom_range(0, 4095)) - 2048;
    endcase
  endfunction

  initial begin
    int hs;
    wr_t w;
    rst = 1'b1; req_valid = 1'b0; finish = 1'b0;
    req_kind = '0; req_funct3 = '0; req_alt = 1'b0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    last_data = '0;

    do_reset();
    check("rst_ready", req_ready, 1);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);

    // Encoding vectors, then fill to capacity and terminate.
    run_req(0, 0, 0, 3, 1, 2, 0);
    check("vec_r_add", last_data, 32'h002081B3);
    run_req(0, 0, 1, 3, 1, 2, 0);
    check("vec_r_sub", last_data, 32'h402081B3);
    run_req(1, 0, 0, 5, 0, 0, -1);
    check("vec_addi", last_data, 32'hFFF00293);
    repeat (2) @(negedge clk);
    check("addr_hold", imem_addr, 32'h8);
    check("wdata_hold", imem_wdata, 32'hFFF00293);
    run_finish();
    check("term_count4", count, 4);
    poke_done();

    // Control-flow vectors and error handling.
    do_reset();
    run_req(4, 0, 0, 0, 1, 2, 8);
    check("vec_beq", last_data, 32'h00208463);
    run_req(5, 0, 0, 1, 0, 0, 2048);
    check("vec_jal", last_data, 32'h001000EF);
    run_req(4, 0, 0, 0, 1, 2, 3);
    run_req(7, 0, 0, 1, 1, 1, 0);
    check("err_cnt", count, 2);
    check("err_set", err, 1);
    run_req(2, 2, 0, 7, 3, 0, 16);
    check("err_sticky", err, 1);

    // Request and finish together: request first, held finish then terminates.
    do_reset();
    do_req(0, 0, 0, 3, 1, 2, 0, 1'b1, hs);
    repeat (5) @(negedge clk);
    finish = 1'b0;
    check("prio_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      w = wq.pop_front();
      check("prio_req_data", w.data, 32'h002081B3);
      check("prio_req_addr", w.addr, 0);
      check("prio_req_lat", w.cyc, hs + 2);
      w = wq.pop_front();
      check("prio_term_data", w.data, 32'hFFFF_FFFF);
      check("prio_term_addr", w.addr, 4);
    end
    check("prio_done", done, 1);

    // Reset while in WRITE aborts the write.
    do_reset();
    do_req(1, 0, 0, 2, 1, 0, 5, 1'b0, hs);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_we", imem_we, 0);
    check("abort_count", count, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    check("abort_no_wr", wq.size(), 0);

    // Randomized programs.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (m_done) begin
        poke_done();
        do_reset();
      end else if (m_cnt == DEPTH - 1 || $urandom_range(0, 19) == 0) begin
        run_finish();
      end else begin
        run_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), rand_imm());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
